// File: rtl/xor_stream_decrypt_rx_if.sv
// Serial ciphertext input and plaintext byte output of the XOR stream receiver.
// The receiver sits on the slave side; the cipher/consumer environment is the master.
interface xor_stream_decrypt_rx_if;
    logic       iSer_data;
    logic       iSer_start;
    logic       iSer_end;
    logic [7:0] oByte;
    logic       oByte_valid;
    logic       iByte_ready;

    modport master (
        output iSer_data, iSer_start, iSer_end, iByte_ready,
        input  oByte, oByte_valid
    );

    modport slave (
        input  iSer_data, iSer_start, iSer_end, iByte_ready,
        output oByte, oByte_valid
    );
endinterface

// File: rtl/xor_stream_decrypt_rx.sv
// Deserializes a framed LSB-first ciphertext stream, XORs each byte with the
// repeating key and hands plaintext out through a 2-entry valid/ready FIFO.
module xor_stream_decrypt_rx #(
    parameter int KEY_SIZE = 32,
    parameter int MSG_SIZE = 512
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic [KEY_SIZE-1:0]    iKey,
    input  logic                   iKey_load,
    xor_stream_decrypt_rx_if.slave bus,
    output logic                   oFrame_done,
    output logic                   oFrame_err,
    output logic                   oBusy
);
    localparam int K  = KEY_SIZE / 8;
    localparam int CW = $clog2(MSG_SIZE) + 1;
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(MSG_SIZE - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_e;

    state_e            state_q, state_d;
    logic [K-1:0][7:0] key_q;
    logic [7:0]        sreg_q, sreg_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [IW-1:0]     byte_idx_q, byte_idx_d;
    logic [1:0][7:0]   mem_q, mem_d;
    logic              wr_q, wr_d, rd_q, rd_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              push, pop, ovf, err_set, err_clr;
    logic [7:0]        plain;

    // The frame in flight keeps the key it started with.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            key_q <= '0;
        else if (iKey_load && state_q != RECV)
            key_q <= iKey;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sreg_q     <= '0;
            bit_cnt_q  <= '0;
            byte_idx_q <= '0;
            mem_q      <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
            mem_q      <= mem_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        done_d     = 1'b0;
        push       = 1'b0;
        plain      = '0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        if (ena) begin
            if (state_q == DONE)
                state_d = IDLE;
            if (bus.iSer_start) begin
                // Inside RECV a start aborts the frame in flight; elsewhere it opens a fresh one.
                if (state_q == RECV)
                    err_set = 1'b1;
                else
                    err_clr = 1'b1;
                sreg_d[0]  = bus.iSer_data;
                bit_cnt_d  = CW'(1);
                byte_idx_d = '0;
                state_d    = RECV;
                if (bus.iSer_end) begin
                    // Frames are whole bytes, so a 1-bit frame is always short.
                    state_d = DONE;
                    err_set = 1'b1;
                end
            end else if (state_q == RECV) begin
                sreg_d[bit_cnt_q[2:0]] = bus.iSer_data;
                bit_cnt_d = bit_cnt_q + CW'(1);
                if (bit_cnt_q[2:0] == 3'd7) begin
                    push       = 1'b1;
                    plain      = {bus.iSer_data, sreg_q[6:0]} ^ key_q[byte_idx_q];
                    byte_idx_d = (byte_idx_q == LAST_IDX) ? '0 : byte_idx_q + IW'(1);
                end
                if (bus.iSer_end || bit_cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    if (bus.iSer_end && bit_cnt_q == LAST_BIT)
                        done_d = 1'b1;
                    else
                        err_set = 1'b1;
                end
            end
        end
    end

    // Output FIFO keeps popping even while the serial side is frozen.
    always_comb begin
        pop   = (cnt_q != 2'd0) && bus.iByte_ready;
        ovf   = push && (cnt_q == 2'd2) && !pop;
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push && !ovf) begin
            mem_d[wr_q] = plain;
            wr_d        = ~wr_q;
        end
        if (pop)
            rd_d = ~rd_q;
        cnt_d = cnt_q + ((push && !ovf) ? 2'd1 : 2'd0) - (pop ? 2'd1 : 2'd0);
    end

    assign err_d           = (err_q && !err_clr) || err_set || ovf;
    assign bus.oByte       = (cnt_q != 2'd0) ? mem_q[rd_q] : 8'h00;
    assign bus.oByte_valid = (cnt_q != 2'd0);
    assign oFrame_done     = done_q;
    assign oFrame_err      = err_q;
    assign oBusy           = (state_q == RECV);
endmodule

// File: tb/tb_xor_stream_decrypt_rx.sv
// Directed + randomized bench for xor_stream_decrypt_rx against a byte-level XOR model.
module tb_xor_stream_decrypt_rx;
    localparam int KS = 32;
    localparam int MS = 512;
    localparam int NB = MS / 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic        key_load = 1'b0;
    logic [31:0] key = '0;
    logic        done, err, busy;

    xor_stream_decrypt_rx_if bus();

    xor_stream_decrypt_rx #(.KEY_SIZE(KS), .MSG_SIZE(MS)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .iKey(key), .iKey_load(key_load),
        .bus(bus), .oFrame_done(done), .oFrame_err(err), .oBusy(busy)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    logic [7:0]  tx [NB];
    logic [7:0]  got [$];
    logic [7:0]  expq [$];
    logic [31:0] mkey = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.oByte_valid && bus.iByte_ready) got.push_back(bus.oByte);
            if (done) done_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exv);
        n_chk++;
        assert (obs === exv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [31:0] k);
        key = k; key_load = 1'b1;
        tick();
        key_load = 1'b0;
        mkey = k;
    endtask

    task automatic new_tx();
        for (int i = 0; i < NB; i++) tx[i] = 8'($urandom);
    endtask

    // Ciphertext byte j decrypts with key byte (j mod 4) of the frame's key.
    task automatic model(input int nbytes);
        for (int j = 0; j < nbytes; j++) expq.push_back(tx[j] ^ mkey[8*(j%4) +: 8]);
    endtask

    // Sends frame bits [from, to); start strobe on bit 0, end strobe on bit to-1 if asked.
    task automatic send_bits(input int from, input int to, input bit do_end);
        for (int i = from; i < to; i++) begin
            bus.iSer_data  = tx[i/8][i%8];
            bus.iSer_start = (i == 0);
            bus.iSer_end   = do_end && (i == to - 1);
            tick();
            key_load = 1'b0;
        end
        bus.iSer_start = 1'b0;
        bus.iSer_end   = 1'b0;
    endtask

    task automatic cmp_bytes(input string tag);
        repeat (4) tick();
        chk({tag, "_count"}, got.size(), expq.size());
        for (int i = 0; i < expq.size() && i < got.size(); i++) chk(tag, got[i], expq[i]);
        got.delete();
        expq.delete();
    endtask

    initial begin
        bus.iSer_data = 1'b0; bus.iSer_start = 1'b0; bus.iSer_end = 1'b0; bus.iByte_ready = 1'b1;
        #12;
        chk("rst_byte", bus.oByte, 0);
        chk("rst_valid", bus.oByte_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        tick();
        rst_n = 1'b1; ena = 1'b1;
        tick();

        // All-zero ciphertext reveals the key byte directly.
        load_key(32'hA5A5_A5A5);
        for (int i = 0; i < NB; i++) tx[i] = 8'h00;
        for (int i = 0; i < NB; i++) expq.push_back(8'hA5);
        done_cnt = 0;
        send_bits(0, MS, 1'b1);
        cmp_bytes("t1_byte");
        chk("t1_done", done_cnt, 1);
        chk("t1_err", err, 0);

        // Ciphertext equal to the key stream decrypts to zeros.
        load_key(32'h4433_2211);
        for (int i = 0; i < NB; i++) tx[i] = 8'(8'h11 * ((i % 4) + 1));
        for (int i = 0; i < NB; i++) expq.push_back(8'h00);
        done_cnt = 0;
        send_bits(0, MS, 1'b1);
        cmp_bytes("t2_byte");
        chk("t2_done", done_cnt, 1);

        // Random key and data; a key load mid-frame must be ignored.
        load_key($urandom);
        new_tx();
        model(NB);
        done_cnt = 0;
        send_bits(0, 50, 1'b0);
        key = $urandom; key_load = 1'b1;
        send_bits(50, MS, 1'b1);
        cmp_bytes("rnd_byte");
        chk("rnd_done", done_cnt, 1);
        chk("rnd_err", err, 0);

        // Early end at bit 100: 12 whole bytes, partial byte discarded.
        new_tx();
        model(12);
        done_cnt = 0;
        send_bits(0, 101, 1'b1);
        cmp_bytes("t4_byte");
        chk("t4_err", err, 1);
        chk("t4_done", done_cnt, 0);
        chk("t4_busy", busy, 0);

        // Restart at bit 40, then one clean frame.
        new_tx();
        model(5);
        done_cnt = 0;
        send_bits(0, 40, 1'b0);
        chk("t5_err_pre", err, 0);
        chk("t5_busy", busy, 1);
        new_tx();
        model(NB);
        send_bits(0, MS, 1'b1);
        cmp_bytes("t5_byte");
        chk("t5_err_restart", err, 1);
        chk("t5_done_restart", done_cnt, 1);
        new_tx();
        model(NB);
        done_cnt = 0;
        send_bits(0, MS, 1'b1);
        cmp_bytes("t5_clean_byte");
        chk("t5_clean_err", err, 0);
        chk("t5_clean_done", done_cnt, 1);

        // Last bit arrives without an end strobe.
        new_tx();
        model(NB);
        done_cnt = 0;
        send_bits(0, MS, 1'b0);
        cmp_bytes("noend_byte");
        chk("noend_err", err, 1);
        chk("noend_done", done_cnt, 0);
        chk("noend_busy", busy, 0);

        // Consumer stalled: two bytes held, third overflows.
        new_tx();
        bus.iByte_ready = 1'b0;
        send_bits(0, 23, 1'b0);
        chk("t3_err_pre", err, 0);
        chk("t3_valid", bus.oByte_valid, 1);
        send_bits(23, MS, 1'b1);
        repeat (3) tick();
        chk("t3_err", err, 1);
        chk("t3_head", bus.oByte, tx[0] ^ mkey[7:0]);
        model(2);
        bus.iByte_ready = 1'b1;
        cmp_bytes("t3_byte");
        chk("t3_empty", bus.oByte_valid, 0);

        // Freeze for 5 cycles mid-byte with strobes toggling.
        new_tx();
        model(NB);
        done_cnt = 0;
        send_bits(0, 12, 1'b0);
        ena = 1'b0;
        repeat (5) begin
            bus.iSer_data = 1'($urandom); bus.iSer_start = 1'b1; bus.iSer_end = 1'b1;
            tick();
        end
        chk("t6_frz_busy", busy, 1);
        chk("t6_frz_err", err, 0);
        bus.iSer_start = 1'b0; bus.iSer_end = 1'b0; ena = 1'b1;
        send_bits(12, MS, 1'b1);
        cmp_bytes("t6_frz_byte");
        chk("t6_frz_done", done_cnt, 1);
        chk("t6_frz_err2", err, 0);

        // Asynchronous reset mid-frame with data queued and an error pending.
        new_tx();
        bus.iByte_ready = 1'b0;
        send_bits(0, 30, 1'b0);
        chk("t6_pre_valid", bus.oByte_valid, 1);
        chk("t6_pre_err", err, 1);
        chk("t6_pre_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_byte", bus.oByte, 0);
        chk("t6_rst_valid", bus.oByte_valid, 0);
        chk("t6_rst_err", err, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        tick();
        rst_n = 1'b1;
        got.delete();
        expq.delete();

        // Key register came back as zero, so plaintext equals ciphertext.
        mkey = '0;
        bus.iByte_ready = 1'b1;
        new_tx();
        model(NB);
        done_cnt = 0;
        send_bits(0, MS, 1'b1);
        cmp_bytes("post_rst_byte");
        chk("post_rst_done", done_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
